// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if
//   Bundles the two requester ports and the register-file bus that
//   regfile_arbiter serializes onto.
//   Requester A/B : reqX, weX, addrX, wdataX  -> arbiter
//                   ackX, rdataX              <- arbiter
//   Register file : regAddr, regIn, regRead, regWrite <- arbiter
//                   regOut                            -> arbiter
//   Status        : busy                              <- arbiter
//   slave  : arbiter side
//   master : requesters + register file side
interface regfile_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              reqA;
  logic              reqB;
  logic              weA;
  logic              weB;
  logic [ADDR_W-1:0] addrA;
  logic [ADDR_W-1:0] addrB;
  logic [DATA_W-1:0] wdataA;
  logic [DATA_W-1:0] wdataB;
  logic              ackA;
  logic              ackB;
  logic [DATA_W-1:0] rdataA;
  logic [DATA_W-1:0] rdataB;
  logic [ADDR_W-1:0] regAddr;
  logic [DATA_W-1:0] regIn;
  logic              regRead;
  logic              regWrite;
  logic [DATA_W-1:0] regOut;
  logic              busy;

  modport slave (
    input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, regOut,
    output ackA, ackB, rdataA, rdataB, regAddr, regIn, regRead, regWrite, busy
  );

  modport master (
    output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, regOut,
    input  ackA, ackB, rdataA, rdataB, regAddr, regIn, regRead, regWrite, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Round-robin arbiter and access sequencer for the 8x16 single-port
//   register file. Two requesters (A, B) share the register-file bus; each
//   transaction takes IDLE -> ACCESS -> ACK (3 cycles). Read data is held
//   per port in rdataA/rdataB; completion is a one-cycle ackA/ackB pulse.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : regfile_arbiter_if.slave (requesters, register-file bus, busy)
//   All outputs are registered.
module regfile_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic              prio_q,      prio_d;      // 0 = A has priority, 1 = B
  logic              sel_q,       sel_d;       // port being served
  logic              ack_a_q,     ack_a_d;
  logic              ack_b_q,     ack_b_d;
  logic              reg_read_q,  reg_read_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] reg_addr_q,  reg_addr_d;
  logic [DATA_W-1:0] reg_in_q,    reg_in_d;
  logic [DATA_W-1:0] rdata_a_q,   rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q,   rdata_b_d;
  logic              busy_q,      busy_d;

  logic              grant_b;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    sel_d       = sel_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    reg_read_d  = 1'b0;
    reg_write_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_in_d    = reg_in_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    grant_b     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.reqA || bus.reqB) begin
          // B wins when it is the only requester, or on a tie when prio says B
          grant_b = bus.reqB && (!bus.reqA || prio_q);
          sel_d   = grant_b;
          // Pointer always moves to the loser, requesting or not
          prio_d  = !grant_b;
          if (grant_b) begin
            reg_addr_d  = bus.addrB;
            reg_in_d    = bus.wdataB;
            reg_write_d = bus.weB;
            reg_read_d  = !bus.weB;
          end else begin
            reg_addr_d  = bus.addrA;
            reg_in_d    = bus.wdataA;
            reg_write_d = bus.weA;
            reg_read_d  = !bus.weA;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // regOut is sampled while regRead is still asserted
        if (reg_read_q) begin
          if (sel_q) rdata_b_d = bus.regOut;
          else       rdata_a_d = bus.regOut;
        end
        ack_a_d = !sel_q;
        ack_b_d = sel_q;
        state_d = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_in_q    <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      reg_read_q  <= reg_read_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_in_q    <= reg_in_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ackA     = ack_a_q;
  assign bus.ackB     = ack_b_q;
  assign bus.rdataA   = rdata_a_q;
  assign bus.rdataB   = rdata_b_q;
  assign bus.regAddr  = reg_addr_q;
  assign bus.regIn    = reg_in_q;
  assign bus.regRead  = reg_read_q;
  assign bus.regWrite = reg_write_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  logic clk;
  logic rst_n;

  regfile_arbiter_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  regfile_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: 8x16, write commits on the edge, regOut only
  // meaningful while regRead is high (16'hDEAD stands in for a floating bus).
  logic [15:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
  always @(posedge clk) if (bus.regWrite) mem[bus.regAddr] <= bus.regIn;
  assign bus.regOut = bus.regRead ? mem[bus.regAddr] : 16'hDEAD;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.reqA = 0; bus.reqB = 0; bus.weA = 0; bus.weB = 0;
    bus.addrA = 0; bus.addrB = 0; bus.wdataA = 0; bus.wdataB = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".ack"},   {30'd0, bus.ackA, bus.ackB}, 32'd0);
    check({name, ".rw"},    {30'd0, bus.regRead, bus.regWrite}, 32'd0);
    check({name, ".addr"},  {29'd0, bus.regAddr}, 32'd0);
    check({name, ".in"},    {16'd0, bus.regIn}, 32'd0);
    check({name, ".rdata"}, {bus.rdataA, bus.rdataB}, 32'd0);
    check({name, ".busy"},  {31'd0, bus.busy}, 32'd0);
  endtask

  // Single-port transaction with cycle-by-cycle checks.
  task automatic run_txn(input bit port, input bit we, input logic [2:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_a,
                         input logic [15:0] exp_b);
    @(negedge clk);
    if (port) begin bus.reqB = 1; bus.weB = we; bus.addrB = addr; bus.wdataB = wdata; end
    else      begin bus.reqA = 1; bus.weA = we; bus.addrA = addr; bus.wdataA = wdata; end
    @(posedge clk); @(negedge clk);
    check("acc.write", {31'd0, bus.regWrite}, {31'd0, we});
    check("acc.read",  {31'd0, bus.regRead},  {31'd0, !we});
    check("acc.addr",  {29'd0, bus.regAddr},  {29'd0, addr});
    check("acc.in",    {16'd0, bus.regIn},    {16'd0, wdata});
    check("acc.busy",  {31'd0, bus.busy}, 32'd1);
    check("acc.noack", {30'd0, bus.ackA, bus.ackB}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("ack.pulse", {30'd0, bus.ackA, bus.ackB}, port ? 32'd1 : 32'd2);
    check("ack.rw",    {30'd0, bus.regRead, bus.regWrite}, 32'd0);
    check("ack.rdata", {bus.rdataA, bus.rdataB}, {exp_a, exp_b});
    bus.reqA = 0; bus.reqB = 0;
    @(posedge clk); @(negedge clk);
    check("idle.ack",  {30'd0, bus.ackA, bus.ackB}, 32'd0);
    check("idle.busy", {31'd0, bus.busy}, 32'd0);
    check("idle.hold", {13'd0, bus.regAddr, bus.regIn}, {13'd0, addr, wdata});
  endtask

  // Both ports request together; each drops req on seeing its ack.
  task automatic run_pair(input bit wea, input logic [2:0] aa, input logic [15:0] wa,
                          input bit web, input logic [2:0] ab, input logic [15:0] wb,
                          output int ta, output int tb);
    bit da = 0, db = 0;
    ta = -1; tb = -1;
    @(negedge clk);
    bus.reqA = 1; bus.weA = wea; bus.addrA = aa; bus.wdataA = wa;
    bus.reqB = 1; bus.weB = web; bus.addrB = ab; bus.wdataB = wb;
    for (int c = 1; c <= 20 && !(da && db); c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ackA && !da) begin da = 1; ta = c; bus.reqA = 0; end
      if (bus.ackB && !db) begin db = 1; tb = c; bus.reqB = 0; end
    end
    if (!(da && db)) begin
      failures++; checks++;
      $display("FAIL pair.timeout: got ackA_seen=%0d ackB_seen=%0d expected both", da, db);
    end
    bus.reqA = 0; bus.reqB = 0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int ta, tb, na, nb, alt_err, last;
    bit done;

    // memory starts as 16'h1000 + index
    vecs[0]  = '{0, 1, 3'd3, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 3'd3, 16'h0F0F, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1, 0, 3'd3, 16'h1111, 16'hBEEF, 16'hBEEF};
    vecs[3]  = '{1, 1, 3'd0, 16'h5A5A, 16'hBEEF, 16'hBEEF};
    vecs[4]  = '{0, 0, 3'd0, 16'h2222, 16'h5A5A, 16'hBEEF};
    vecs[5]  = '{1, 0, 3'd7, 16'h3333, 16'h5A5A, 16'h1007};
    vecs[6]  = '{0, 0, 3'd6, 16'h4444, 16'h1006, 16'h1007};
    vecs[7]  = '{1, 1, 3'd7, 16'hFFFF, 16'h1006, 16'h1007};
    vecs[8]  = '{1, 0, 3'd7, 16'h5555, 16'h1006, 16'hFFFF};
    vecs[9]  = '{0, 1, 3'd1, 16'h0000, 16'h1006, 16'hFFFF};
    vecs[10] = '{0, 0, 3'd1, 16'h6666, 16'h0000, 16'hFFFF};

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset0");
    rst_n = 1;

    for (int i = 0; i < 11; i++)
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_a, vecs[i].exp_b);

    // Mid-cycle asynchronous reset clears everything immediately
    @(posedge clk); #2; rst_n = 0; #1;
    check_all_zero("reset_mid");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("idle5.rw", {30'd0, bus.regRead, bus.regWrite}, 32'd0);
    end

    // Simultaneous requests after reset: A first, then B
    run_pair(0, 3'd3, 16'h0, 0, 3'd7, 16'h0, ta, tb);
    check("simul.tA", ta, 32'd2);
    check("simul.tB", tb, 32'd5);
    check("simul.rdata", {bus.rdataA, bus.rdataB}, {16'hBEEF, 16'hFFFF});
    // prio is back on A: A wins the next tie too
    run_pair(0, 3'd0, 16'h0, 0, 3'd6, 16'h0, ta, tb);
    check("prio.tA", ta, 32'd2);
    check("prio.tB", tb, 32'd5);
    check("prio.rdata", {bus.rdataA, bus.rdataB}, {16'h5A5A, 16'h1006});

    // Fairness: both held for 10 transactions
    na = 0; nb = 0; alt_err = 0; last = 1; done = 0;
    @(negedge clk);
    bus.reqA = 1; bus.weA = 0; bus.addrA = 3'd3;
    bus.reqB = 1; bus.weB = 0; bus.addrB = 3'd7;
    for (int c = 0; c < 45 && !done; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ackA && bus.ackB) alt_err++;
      if (bus.ackA) begin if (last == 0) alt_err++; last = 0; na++; end
      if (bus.ackB) begin if (last == 1) alt_err++; last = 1; nb++; end
      if (na + nb == 10) begin done = 1; bus.reqA = 0; bus.reqB = 0; end
    end
    bus.reqA = 0; bus.reqB = 0;
    check("fair.acksA", na, 32'd5);
    check("fair.acksB", nb, 32'd5);
    check("fair.alternate", alt_err, 32'd0);
    check("fair.rdata", {bus.rdataA, bus.rdataB}, {16'hBEEF, 16'hFFFF});
    @(posedge clk);

    // A alone moves prio to B
    run_txn(0, 1, 3'd2, 16'h2222, 16'hBEEF, 16'hFFFF);
    // Cross-port: B writes 7 first, A's read of 7 then sees it
    run_pair(0, 3'd7, 16'h0, 1, 3'd7, 16'h1234, ta, tb);
    check("cross.tB", tb, 32'd2);
    check("cross.tA", ta, 32'd5);
    check("cross.rdata", {bus.rdataA, bus.rdataB}, {16'h1234, 16'hFFFF});

    // Reset during the ACCESS cycle of a write
    @(negedge clk);
    bus.reqA = 1; bus.weA = 1; bus.addrA = 3'd5; bus.wdataA = 16'hAAAA;
    @(posedge clk); #1;
    check("rstwr.write_hi", {31'd0, bus.regWrite}, 32'd1);
    #1; rst_n = 0; bus.reqA = 0; #1;
    check("rstwr.write_drop", {31'd0, bus.regWrite}, 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rstwr.noack", {30'd0, bus.ackA, bus.ackB}, 32'd0);
    end
    run_txn(0, 0, 3'd5, 16'h0, 16'h1005, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global.timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
